// File: rtl/accumulator_scheduler_pkg.sv
// Shared definitions for the accumulator scheduler: sweep FSM state
// encodings, default sizes and the slot-index width helper.
package accumulator_scheduler_pkg;

    localparam int ACC_WIDTH_DEFAULT = 16;
    localparam int NUM_SLOTS_DEFAULT = 8;

    typedef enum logic [1:0] {
        ACCSCHED_IDLE  = 2'd0,
        ACCSCHED_SWEEP = 2'd1,
        ACCSCHED_DRAIN = 2'd2
    } sched_state_t;

    // max(1, clog2(n)) so a slot index is never zero bits wide
    function automatic int slot_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/accumulator_state_bank.sv
// Per-slot accumulator state storage.
// Ports:
//   clk, reset    clock, asynchronous active-high reset (clears every entry)
//   i_rd_slot     read address; o_rd_data follows it combinationally
//   i_wr_en       write strobe for the single synchronous write port
//   i_wr_slot     write address
//   i_wr_data     write data
module accumulator_state_bank #(
    parameter int NUM_SLOTS  = 8,
    parameter int ACC_WIDTH  = 16,
    parameter int SLOT_WIDTH = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic        [SLOT_WIDTH-1:0] i_rd_slot,
    output logic signed [ACC_WIDTH-1:0]  o_rd_data,
    input  logic                        i_wr_en,
    input  logic        [SLOT_WIDTH-1:0] i_wr_slot,
    input  logic signed [ACC_WIDTH-1:0]  i_wr_data
);

    logic signed [ACC_WIDTH-1:0] r_mem [NUM_SLOTS];

    assign o_rd_data = r_mem[i_rd_slot];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_slot] <= i_wr_data;
        end
    end

endmodule

// File: rtl/accumulator_scheduler.sv
// Time-multiplexes one external accumulator datapath across NUM_SLOTS
// correlator slots. Each accepted sample launches a sweep that issues every
// slot in turn, feeds the stored sum back to the datapath one cycle later
// (matching its input register), writes the result back, and emits a dump
// record whenever a slot is cleared at a code-period boundary.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   sample_valid    start a sweep (dropped and flagged if a sweep is running)
//   slot_enable     per-slot enable; a disabled slot is zeroed
//   dump_req        per-slot dump request pulses, latched until serviced
//   busy            sweep in progress (issue cycles plus one drain cycle)
//   slot_idx        slot currently issued to the front-end muxes
//   acc_in/acc_clear  stored sum and clear to the datapath (apply cycle only)
//   acc_out         updated sum from the datapath
//   dump_valid/dump_slot/dump_value  completed-sum record
//   overrun         sticky dropped-sample flag; overrun_clear clears it
module accumulator_scheduler
    import accumulator_scheduler_pkg::*;
#(
    parameter  int NUM_SLOTS  = NUM_SLOTS_DEFAULT,
    parameter  int ACC_WIDTH  = ACC_WIDTH_DEFAULT,
    localparam int SLOT_WIDTH = slot_width(NUM_SLOTS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         sample_valid,
    input  logic        [NUM_SLOTS-1:0]  slot_enable,
    input  logic        [NUM_SLOTS-1:0]  dump_req,
    output logic                         busy,
    output logic        [SLOT_WIDTH-1:0] slot_idx,
    output logic signed [ACC_WIDTH-1:0]  acc_in,
    output logic                         acc_clear,
    input  logic signed [ACC_WIDTH-1:0]  acc_out,
    output logic                         dump_valid,
    output logic        [SLOT_WIDTH-1:0] dump_slot,
    output logic signed [ACC_WIDTH-1:0]  dump_value,
    output logic                         overrun,
    input  logic                         overrun_clear
);

    localparam logic [SLOT_WIDTH-1:0] LAST_SLOT = SLOT_WIDTH'(NUM_SLOTS - 1);

    sched_state_t r_state, w_state_nxt;

    logic        [SLOT_WIDTH-1:0] r_slot_p0;
    logic                         r_busy;
    logic                         w_issue;
    logic                         w_last;
    logic signed [ACC_WIDTH-1:0]  w_rd_data;
    logic                         w_pend_issue;

    logic                         r_vld_p1;
    logic        [SLOT_WIDTH-1:0] r_slot_p1;
    logic                         r_en_p1;
    logic                         r_clr_p1;
    logic signed [ACC_WIDTH-1:0]  r_acc_in_p1;
    logic signed [ACC_WIDTH-1:0]  w_wr_data;

    logic                         r_vld_p2;
    logic        [SLOT_WIDTH-1:0] r_slot_p2;
    logic signed [ACC_WIDTH-1:0]  r_value_p2;

    logic        [NUM_SLOTS-1:0]  r_pending, w_pending_nxt;
    logic                         r_overrun;

    // A disabled slot is forced to zero instead of taking the datapath result
    function automatic logic signed [ACC_WIDTH-1:0] writeback(
        input logic en, input logic signed [ACC_WIDTH-1:0] v);
        return en ? v : '0;
    endfunction

    assign w_issue      = (r_state == ACCSCHED_SWEEP);
    assign w_last       = (r_slot_p0 == LAST_SLOT);
    // A request arriving during the issue cycle is serviced by this apply
    assign w_pend_issue = r_pending[r_slot_p0] | dump_req[r_slot_p0];
    assign w_wr_data    = writeback(r_en_p1, acc_out);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ACCSCHED_IDLE:  if (sample_valid) w_state_nxt = ACCSCHED_SWEEP;
            ACCSCHED_SWEEP: if (w_last)       w_state_nxt = ACCSCHED_DRAIN;
            ACCSCHED_DRAIN:                   w_state_nxt = ACCSCHED_IDLE;
            default:                          w_state_nxt = ACCSCHED_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ACCSCHED_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ACCSCHED_IDLE);
        end
    end

    // Issue stage (p0): slot counter drives the front-end muxes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_slot_p0 <= '0;
        end else if (w_issue) begin
            r_slot_p0 <= w_last ? '0 : r_slot_p0 + 1'b1;
        end
    end

    accumulator_state_bank #(
        .NUM_SLOTS (NUM_SLOTS),
        .ACC_WIDTH (ACC_WIDTH),
        .SLOT_WIDTH(SLOT_WIDTH)
    ) u_bank (
        .clk      (clk),
        .reset    (reset),
        .i_rd_slot(r_slot_p0),
        .o_rd_data(w_rd_data),
        .i_wr_en  (r_vld_p1),
        .i_wr_slot(r_slot_p1),
        .i_wr_data(w_wr_data)
    );

    // Apply stage (p1): stored sum and clear presented while the datapath
    // combines them with the term it registered during the issue cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld_p1    <= 1'b0;
            r_slot_p1   <= '0;
            r_en_p1     <= 1'b0;
            r_clr_p1    <= 1'b0;
            r_acc_in_p1 <= '0;
        end else begin
            r_vld_p1    <= w_issue;
            r_slot_p1   <= r_slot_p0;
            r_en_p1     <= w_issue & slot_enable[r_slot_p0];
            r_clr_p1    <= w_issue & slot_enable[r_slot_p0] & w_pend_issue;
            r_acc_in_p1 <= w_issue ? w_rd_data : '0;
        end
    end

    // Pending bits drop when the slot is cleared or disabled; a new request
    // in that same cycle keeps the bit set for the next sample
    always_comb begin
        w_pending_nxt = r_pending;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (r_vld_p1 && (r_slot_p1 == SLOT_WIDTH'(i)) && (r_clr_p1 || !r_en_p1)) begin
                w_pending_nxt[i] = 1'b0;
            end
            if (dump_req[i]) begin
                w_pending_nxt[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pending <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            r_overrun <= (sample_valid && (r_state != ACCSCHED_IDLE)) ||
                         (r_overrun && !overrun_clear);
        end
    end

    // Dump stage (p2): pre-clear sum of a slot that was just cleared
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld_p2   <= 1'b0;
            r_slot_p2  <= '0;
            r_value_p2 <= '0;
        end else begin
            r_vld_p2 <= r_vld_p1 & r_clr_p1;
            if (r_vld_p1 && r_clr_p1) begin
                r_slot_p2  <= r_slot_p1;
                r_value_p2 <= r_acc_in_p1;
            end
        end
    end

    assign busy       = r_busy;
    assign slot_idx   = r_slot_p0;
    assign acc_in     = r_acc_in_p1;
    assign acc_clear  = r_clr_p1;
    assign dump_valid = r_vld_p2;
    assign dump_slot  = r_slot_p2;
    assign dump_value = r_value_p2;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_accumulator_scheduler.sv
// Bench: scheduler driving a behavioural stand-in for accumulator_sw
// (registered +/-sample term, output = (clear ? 0 : acc_in) + term).
module tb_accumulator_scheduler;

    localparam int NS = 4;
    localparam int AW = 16;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 sample_valid;
    logic [NS-1:0]        slot_enable;
    logic [NS-1:0]        dump_req;
    logic                 busy;
    logic [1:0]           slot_idx;
    logic signed [AW-1:0] acc_in;
    logic                 acc_clear;
    logic signed [AW-1:0] acc_out;
    logic                 dump_valid;
    logic [1:0]           dump_slot;
    logic signed [AW-1:0] dump_value;
    logic                 overrun;
    logic                 overrun_clear;

    logic signed [AW-1:0] sample;
    logic [NS-1:0]        ca_code;
    logic signed [AW-1:0] r_sw_term;

    always #5 clk = ~clk;

    accumulator_scheduler #(.NUM_SLOTS(NS), .ACC_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .sample_valid(sample_valid),
        .slot_enable(slot_enable), .dump_req(dump_req), .busy(busy),
        .slot_idx(slot_idx), .acc_in(acc_in), .acc_clear(acc_clear),
        .acc_out(acc_out), .dump_valid(dump_valid), .dump_slot(dump_slot),
        .dump_value(dump_value), .overrun(overrun), .overrun_clear(overrun_clear)
    );

    // accumulator_sw stand-in: one-cycle input pipe on the signed term
    always @(posedge clk) r_sw_term <= ca_code[slot_idx] ? -sample : sample;
    assign acc_out = (acc_clear ? 16'sd0 : acc_in) + r_sw_term;

    typedef struct packed {
        logic [1:0]           slot;
        logic signed [AW-1:0] value;
    } dump_t;

    dump_t                exp_q[$];
    int                   total = 0;
    int                   bad = 0;
    int                   exp_dumps = 0;
    int                   seen_dumps = 0;
    logic signed [AW-1:0] m_bank [NS];
    logic [NS-1:0]        m_pend;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset && dump_valid) begin
            dump_t e;
            seen_dumps++;
            if (exp_q.size() == 0) begin
                chk("dump_unexpected", 32'(dump_slot), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("dump_slot", 32'(dump_slot), 32'(e.slot));
                chk("dump_value", dump_value, e.value);
            end
        end
    end

    task automatic model_reset();
        for (int k = 0; k < NS; k++) m_bank[k] = '0;
        m_pend = '0;
        exp_q.delete();
    endtask

    task automatic model_sample(input logic signed [AW-1:0] s);
        logic signed [AW-1:0] term;
        dump_t d;
        for (int k = 0; k < NS; k++) begin
            term = ca_code[k] ? -s : s;
            if (slot_enable[k]) begin
                if (m_pend[k]) begin
                    d.slot  = 2'(k);
                    d.value = m_bank[k];
                    exp_q.push_back(d);
                    exp_dumps++;
                    m_bank[k] = term;
                    m_pend[k] = 1'b0;
                end else begin
                    m_bank[k] = m_bank[k] + term;
                end
            end else begin
                m_bank[k] = '0;
                m_pend[k] = 1'b0;
            end
        end
    endtask

    // One full sweep; drq_mask is pulsed at cycle T+drq_at (offset from sample_valid)
    task automatic send(input logic signed [AW-1:0] s, input int drq_at, input logic [NS-1:0] drq_mask);
        model_sample(s);
        sample = s;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        chk("busy_start", 32'(busy), 32'd1);
        for (int c = 1; c <= NS + 2; c++) begin
            if (c <= NS) chk("slot_idx", 32'(slot_idx), 32'(c - 1));
            if (c == drq_at) dump_req = drq_mask;
            tick();
            dump_req = '0;
        end
        chk("busy_end", 32'(busy), 32'd0);
        m_pend = m_pend | drq_mask;
    endtask

    task automatic pulse_drq(input logic [NS-1:0] mask);
        dump_req = mask;
        tick();
        dump_req = '0;
        m_pend = m_pend | mask;
    endtask

    task automatic check_bank(input string tag);
        for (int k = 0; k < NS; k++) chk(tag, dut.u_bank.r_mem[k], m_bank[k]);
    endtask

    logic signed [AW-1:0] k_wrap;
    int                   d0;

    initial begin
        reset = 1'b1;
        sample_valid = 1'b0;
        slot_enable = '1;
        dump_req = '0;
        overrun_clear = 1'b0;
        sample = '0;
        ca_code = 4'b0011;
        model_reset();
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_slot", 32'(slot_idx), 32'd0);
        chk("rst_acc_in", acc_in, 32'd0);
        chk("rst_clear", 32'(acc_clear), 32'd0);
        chk("rst_dump", 32'(dump_valid), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        reset = 1'b0;
        tick();

        // per-slot sign accumulation
        for (int i = 0; i < 10; i++) send(16'sd3, 0, '0);
        check_bank("bank_sign");
        k_wrap = -16'sd30;
        chk("bank0_m30", dut.u_bank.r_mem[0], k_wrap);
        chk("no_dump", 32'(seen_dumps), 32'd0);

        // dump of slot 2
        pulse_drq(4'b0100);
        send(16'sd3, 0, '0);
        check_bank("bank_dump");
        chk("dump_cnt1", 32'(seen_dumps), 32'(exp_dumps));

        // overrun: samples at T, T+3 (dropped), T+6 (accepted)
        model_sample(16'sd3);
        sample = 16'sd3;
        sample_valid = 1'b1; tick();
        sample_valid = 1'b0; tick(); tick();
        sample_valid = 1'b1; tick();
        sample_valid = 1'b0;
        chk("ovr_set", 32'(overrun), 32'd1);
        tick(); tick();
        model_sample(16'sd3);
        sample_valid = 1'b1; tick();
        sample_valid = 1'b0;
        chk("ovr_busy", 32'(busy), 32'd1);
        repeat (NS + 2) tick();
        check_bank("bank_ovr");
        chk("ovr_hold", 32'(overrun), 32'd1);
        overrun_clear = 1'b1; tick();
        overrun_clear = 1'b0;
        chk("ovr_clr", 32'(overrun), 32'd0);

        // collision: request in slot 1's clearing apply cycle (T+3)
        pulse_drq(4'b0010);
        d0 = seen_dumps;
        send(16'sd3, 3, 4'b0010);
        chk("coll_first", 32'(seen_dumps - d0), 32'd1);
        send(16'sd3, 0, '0);
        chk("coll_second", 32'(seen_dumps - d0), 32'd2);
        check_bank("bank_coll");

        // wrap and disable
        reset = 1'b1; tick();
        reset = 1'b0;
        model_reset();
        tick();
        send(16'sd32766, 0, '0);
        pulse_drq(4'b0001);
        slot_enable = 4'b1110;
        d0 = seen_dumps;
        send(16'sd3, 0, '0);
        slot_enable = '1;
        k_wrap = -16'sd32767;
        chk("wrap_bank3", dut.u_bank.r_mem[3], k_wrap);
        chk("dis_bank0", dut.u_bank.r_mem[0], 32'd0);
        chk("dis_nodump", 32'(seen_dumps - d0), 32'd0);
        check_bank("bank_wrap");

        // reset mid-sweep, with slot 0's dump in flight at T+3
        pulse_drq(4'b0001);
        sample = 16'sd5;
        sample_valid = 1'b1; tick();
        sample_valid = 1'b0; tick(); tick();
        chk("mid_dump_pre", 32'(dump_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_dump", 32'(dump_valid), 32'd0);
        model_reset();
        tick();
        reset = 1'b0;
        tick();
        check_bank("bank_rst");
        send(16'sd3, 0, '0);
        check_bank("bank_after_rst");

        chk("q_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
